// File: rtl/mux_gate_pkg.sv
// Shared opcode encodings and FSM state type for the mux-based gate arbiter.
package mux_gate_pkg;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_AND  = 3'd0;
  localparam logic [OPW-1:0] OP_OR   = 3'd1;
  localparam logic [OPW-1:0] OP_NOT  = 3'd2;
  localparam logic [OPW-1:0] OP_NAND = 3'd3;
  localparam logic [OPW-1:0] OP_XOR  = 3'd4;
  localparam logic [OPW-1:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mux_gate_unit.sv
// Combinational gate built from one 2:1 mux per bit; A drives the select,
// the opcode picks what the d0/d1 legs carry.
module mux_gate_unit
  import mux_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);
  logic [WIDTH-1:0] d0, d1;

  always_comb begin
    d0  = '0;
    d1  = '0;
    err = 1'b0;
    case (op)
      OP_AND:  begin d0 = '0;  d1 = b;  end
      OP_OR:   begin d0 = b;   d1 = '1; end
      OP_NOT:  begin d0 = '1;  d1 = '0; end
      OP_NAND: begin d0 = '1;  d1 = ~b; end
      OP_XOR:  begin d0 = b;   d1 = ~b; end
      OP_XNOR: begin d0 = ~b;  d1 = b;  end
      default: err = 1'b1;  // both legs 0 -> result forced to 0
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    assign y[i] = a[i] ? d1[i] : d0[i];
  end
endmodule

// File: rtl/mux_gate_arbiter.sv
// Round-robin front end sharing one mux_gate_unit among NREQ requesters,
// with a single registered valid/ready response channel.
module mux_gate_arbiter
  import mux_gate_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [OPW*NREQ-1:0]   req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);
  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IDW-1:0]   id;
  } req_t;

  state_e           state_q, state_d;
  req_t             req_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] gate_y;
  logic             gate_err;

  // First valid requester at or after ptr_q, wrapping.
  always_comb begin
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[j[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst gate keeps the accept strobe quiet while reset is held with requests pending.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found && !rst) req_ready[gnt_idx] = 1'b1;
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && gnt_found) begin
        req_q.op <= req_op[int'(gnt_idx)*OPW +: OPW];
        req_q.a  <= req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        req_q.b  <= req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        req_q.id <= gnt_idx;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= gate_y;
        rsp_err_q  <= gate_err;
        rsp_id_q   <= req_q.id;
      end
      // Pointer moves only on completion, past the requester just served.
      if (state_q == RESP && rsp_ready)
        ptr_q <= (req_q.id == IDW'(NREQ-1)) ? '0 : req_q.id + 1'b1;
    end
  end

  mux_gate_unit #(.WIDTH(WIDTH)) u_gate (
    .op  (req_q.op),
    .a   (req_q.a),
    .b   (req_q.b),
    .y   (gate_y),
    .err (gate_err)
  );

  assign rsp_id   = rsp_id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_mux_gate_arbiter.sv
// Directed bench for mux_gate_arbiter: gate truth table, RR order,
// response back-pressure and reset in flight.
module tb_mux_gate_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err, busy;

  int n_vec = 0;
  int n_err = 0;

  mux_gate_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3]         = op;
    req_a[WIDTH*i +: WIDTH]  = a;
    req_b[WIDTH*i +: WIDTH]  = b;
    req_valid[i]             = 1'b1;
  endtask

  // One full pass with a single requester valid; it drops after the grant.
  task automatic do_op(input string tag, input int i, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input logic exp_e);
    set_req(i, op, a, b);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
    tick();
    req_valid[i] = 1'b0;
    #1;
    chk({tag, "_exec_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, "_id"}, 32'(rsp_id), 32'(i));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    tick();
  endtask

  initial begin
    logic [7:0] rr_exp [4];
    rr_exp = '{8'h10, 8'h20, 8'h30, 8'h40};

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    tick(); tick();
    req_valid = 4'b0101;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();

    // Truth table, A=F0 B=CC
    do_op("and",  0, 3'd0, 8'hF0, 8'hCC, 8'hC0, 1'b0);
    do_op("or",   1, 3'd1, 8'hF0, 8'hCC, 8'hFC, 1'b0);
    do_op("not",  2, 3'd2, 8'hF0, 8'hCC, 8'h0F, 1'b0);
    do_op("nand", 3, 3'd3, 8'hF0, 8'hCC, 8'h3F, 1'b0);
    do_op("xor",  0, 3'd4, 8'hF0, 8'hCC, 8'h3C, 1'b0);
    do_op("xnor", 0, 3'd5, 8'hF0, 8'hCC, 8'hC3, 1'b0);
    do_op("ill7", 3, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1);
    do_op("ill6", 1, 3'd6, 8'hAA, 8'h55, 8'h00, 1'b1);

    // Round robin from pointer 0 with everyone valid
    rst = 1'b1; tick(); rst = 1'b0; tick();
    set_req(0, 3'd0, 8'hF0, 8'h11);
    set_req(1, 3'd0, 8'hF0, 8'h22);
    set_req(2, 3'd0, 8'hF0, 8'h33);
    set_req(3, 3'd0, 8'hF0, 8'h44);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
      chk("rr_exec_ready", 32'(req_ready), 32'd0);
      tick();
      chk("rr_vld", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_data", 32'(rsp_data), 32'(rr_exp[k % 4]));
      tick();
    end
    req_valid = '0;
    tick();

    // Back-pressure: requester 1 served, requester 2 waits
    rsp_ready = 1'b0;
    set_req(1, 3'd0, 8'hF0, 8'hCC);
    #1;
    chk("bp_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    set_req(2, 3'd1, 8'hF0, 8'h0F);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'hC0);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hold_vld", 32'(rsp_valid), 32'd1);
    tick();
    chk("bp_idle_vld", 32'(rsp_valid), 32'd0);
    chk("bp_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid[2] = 1'b0;
    tick();
    chk("bp2_vld", 32'(rsp_valid), 32'd1);
    chk("bp2_data", 32'(rsp_data), 32'hFF);
    chk("bp2_id", 32'(rsp_id), 32'd2);
    tick();

    // Reset during EXEC
    set_req(0, 3'd4, 8'hF0, 8'hCC);
    #1;
    chk("rx_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("rx_busy_exec", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rx_vld", 32'(rsp_valid), 32'd0);
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_data", 32'(rsp_data), 32'd0);
    tick();
    chk("rx_vld2", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    set_req(1, 3'd5, 8'hF0, 8'hCC);
    #1;
    chk("rx_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    chk("rx1_vld", 32'(rsp_valid), 32'd1);
    chk("rx1_id", 32'(rsp_id), 32'd1);
    chk("rx1_data", 32'(rsp_data), 32'hC3);
    tick();
    chk("rx1_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
